// File: rtl/serial_sub_32bit_pkg.sv
// Shared constants and FSM encoding for the slice-serial subtractor.
package serial_sub_32bit_pkg;

    // Default operand width and bits processed per clock.
    localparam int DEF_WIDTH = 32;
    localparam int DEF_SLICE = 8;

    // Controller states: waiting for a request, or stepping through slices.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/serial_sub_32bit_sub_8bit.sv
// Combinational slice subtractor: d = x - y - bi, bo set when the result went negative.
module sub_8bit
    import serial_sub_32bit_pkg::*;
#(
    parameter int W = DEF_SLICE
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         bi,
    output logic [W-1:0] d,
    output logic         bo
);

    // One extra bit captures the borrow out of the top of the slice.
    logic [W:0] res;

    assign res = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, bi};
    assign d   = res[W-1:0];
    assign bo  = res[W];

endmodule

// File: rtl/serial_sub_32bit.sv
// Multi-cycle subtractor: computes a - b - bin one SLICE-bit slice per clock,
// LSB slice first, rippling the borrow between slices through a register.
module serial_sub_32bit
    import serial_sub_32bit_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SLICE = DEF_SLICE
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             overflow
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

    state_t             state_reg;
    state_t             state_next;
    logic [IDX_W-1:0]   idx_reg;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [WIDTH-1:0]   diff_reg;
    logic               chain_reg;     // borrow feeding the current slice
    logic               borrow_reg;
    logic               overflow_reg;
    logic               done_reg;

    logic [SLICE-1:0]   slice_x;
    logic [SLICE-1:0]   slice_y;
    logic [SLICE-1:0]   slice_d;
    logic               slice_bo;
    logic               last_slice;

    // Select the operand slice addressed by the running index.
    assign slice_x    = a_reg[idx_reg*SLICE +: SLICE];
    assign slice_y    = b_reg[idx_reg*SLICE +: SLICE];
    assign last_slice = (idx_reg == LAST_IDX);

    sub_8bit #(
        .W (SLICE)
    ) u_slice (
        .x  (slice_x),
        .y  (slice_y),
        .bi (chain_reg),
        .d  (slice_d),
        .bo (slice_bo)
    );

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state: start is only honoured from IDLE; RUN ends after the last slice.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start)      state_next = RUN;
            RUN:     if (last_slice) state_next = IDLE;
            default:                 state_next = IDLE;
        endcase
    end

    // Status outputs derived from the state.
    always_comb begin
        busy = (state_reg == RUN);
    end

    // Operand capture, slice stepping and result/flag registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            idx_reg      <= '0;
            a_reg        <= '0;
            b_reg        <= '0;
            diff_reg     <= '0;
            chain_reg    <= 1'b0;
            borrow_reg   <= 1'b0;
            overflow_reg <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        a_reg     <= a;
                        b_reg     <= b;
                        chain_reg <= bin;   // slice 0 borrows from bin
                        idx_reg   <= '0;
                    end
                end
                RUN: begin
                    diff_reg[idx_reg*SLICE +: SLICE] <= slice_d;
                    chain_reg <= slice_bo;
                    if (last_slice) begin
                        idx_reg      <= '0;
                        done_reg     <= 1'b1;
                        borrow_reg   <= slice_bo;
                        // slice_d's top bit is the result sign being written now.
                        overflow_reg <= (a_reg[WIDTH-1] != b_reg[WIDTH-1]) &&
                                        (slice_d[SLICE-1] != a_reg[WIDTH-1]);
                    end else begin
                        idx_reg <= idx_reg + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign done     = done_reg;
    assign diff     = diff_reg;
    assign borrow   = borrow_reg;
    assign overflow = overflow_reg;

endmodule

// File: tb/tb_serial_sub_32bit.sv
// Bench for serial_sub_32bit: directed corner cases plus randomized operations
// checked against an arithmetic reference model.
module tb_serial_sub_32bit;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        bin;
    logic        busy;
    logic        done;
    logic [31:0] diff;
    logic        borrow;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    // Last result the DUT should be holding.
    logic [31:0] last_diff = '0;
    logic        last_borrow = 1'b0;
    logic        last_ovf = 1'b0;

    always #5 clock = ~clock;

    serial_sub_32bit dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .a        (a),
        .b        (b),
        .bin      (bin),
        .busy     (busy),
        .done     (done),
        .diff     (diff),
        .borrow   (borrow),
        .overflow (overflow)
    );

    // Reference: whole-word arithmetic on the operands.
    function automatic void model(input logic [31:0] ai, input logic [31:0] bi,
                                  input logic bini, output logic [31:0] d,
                                  output logic bo, output logic ov);
        logic [32:0] full;
        full = {1'b0, ai} - {1'b0, bi} - {32'b0, bini};
        d    = full[31:0];
        bo   = ({1'b0, ai} < ({1'b0, bi} + {32'b0, bini}));
        ov   = (ai[31] != bi[31]) && (d[31] != ai[31]);
    endfunction

    // Runs one operation starting at the next edge. poke>0 holds start high with
    // junk operands for that many RUN edges, which the DUT must ignore.
    task automatic do_op(input logic [31:0] ai, input logic [31:0] bi,
                         input logic bini, input int poke, input string name);
        logic [31:0] ed;
        logic        eb;
        logic        eo;
        int          lat;
        model(ai, bi, bini, ed, eb, eo);
        a = ai; b = bi; bin = bini; start = 1'b1;
        @(posedge clock); #1;
        if (poke > 0) begin
            start = 1'b1; a = 32'h12345678; b = 32'h0; bin = 1'b0;
        end else begin
            start = 1'b0; a = $urandom; b = $urandom; bin = 1'($urandom_range(1));
        end
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL %s accept: busy=%b done=%b required busy=1 done=0", name, busy, done);
        end
        checks++;
        if (diff !== last_diff || borrow !== last_borrow || overflow !== last_ovf) begin
            errors++;
            $display("FAIL %s hold: diff=%h borrow=%b ovf=%b required %h %b %b",
                     name, diff, borrow, overflow, last_diff, last_borrow, last_ovf);
        end
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clock); #1;
            if (k == poke) start = 1'b0;
            if (done === 1'b1) begin
                lat = k;
                break;
            end
        end
        start = 1'b0;
        checks++;
        if (lat != 4) begin
            errors++;
            $display("FAIL %s latency: got %0d edges required 4", name, lat);
        end
        checks++;
        if (diff !== ed || borrow !== eb || overflow !== eo) begin
            errors++;
            $display("FAIL %s result: diff=%h borrow=%b ovf=%b required %h %b %b",
                     name, diff, borrow, overflow, ed, eb, eo);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s busy_at_done: busy=%b required 0", name, busy);
        end
        last_diff = ed; last_borrow = eb; last_ovf = eo;
        $display("op %s a=%h b=%h bin=%0d diff=%h borrow=%0d ovf=%0d lat=%0d",
                 name, ai, bi, bini, diff, borrow, overflow, lat);
    endtask

    // Idle cycles with start low: done must drop and results stay put.
    task automatic idle_check(input int n, input string name);
        for (int k = 0; k < n; k++) begin
            @(posedge clock); #1;
            checks++;
            if (busy !== 1'b0 || done !== 1'b0 || diff !== last_diff ||
                borrow !== last_borrow || overflow !== last_ovf) begin
                errors++;
                $display("FAIL %s idle: busy=%b done=%b diff=%h borrow=%b ovf=%b required 0 0 %h %b %b",
                         name, busy, done, diff, borrow, overflow, last_diff, last_borrow, last_ovf);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || diff !== 32'h0 || borrow !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b diff=%h borrow=%b ovf=%b required all 0",
                     busy, done, diff, borrow, overflow);
        end
        $display("op reset busy=%b done=%b diff=%h", busy, done, diff);
        reset = 1'b0;
        last_diff = '0; last_borrow = 1'b0; last_ovf = 1'b0;
    endtask

    task automatic test_directed();
        do_op(32'h00000005, 32'h00000003, 1'b0, 0, "small");
        idle_check(1, "small");
        do_op(32'h00000000, 32'h00000001, 1'b0, 0, "ripple");
        idle_check(2, "ripple");
        do_op(32'h80000000, 32'h00000001, 1'b0, 0, "ovf");
        idle_check(1, "ovf");
    endtask

    task automatic test_busy_ignore();
        do_op(32'h00000100, 32'h000000FF, 1'b1, 0, "bin_zero");
        idle_check(1, "bin_zero");
        do_op(32'h00000100, 32'h000000FF, 1'b1, 3, "busy_poke");
        idle_check(2, "busy_poke");
    endtask

    task automatic test_back_to_back();
        do_op(32'hFFFFFFFF, 32'h7FFFFFFF, 1'b1, 0, "b2b_0");
        do_op(32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 0, "b2b_1");
        do_op(32'h00000000, 32'h00000000, 1'b1, 0, "b2b_2");
        idle_check(1, "b2b");
    endtask

    task automatic test_reset_midrun();
        a = 32'hDEADBEEF; b = 32'h01234567; bin = 1'b1; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (2) @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || diff !== 32'h0 || borrow !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL abort_clear: busy=%b done=%b diff=%h borrow=%b ovf=%b required all 0",
                     busy, done, diff, borrow, overflow);
        end
        for (int k = 0; k < 4; k++) begin
            @(posedge clock); #1;
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL abort_no_done: done=%b busy=%b required 0 0", done, busy);
            end
        end
        $display("op abort busy=%b done=%b diff=%h", busy, done, diff);
        reset = 1'b0;
        last_diff = '0; last_borrow = 1'b0; last_ovf = 1'b0;
        do_op(32'hCAFEF00D, 32'h0BADF00D, 1'b0, 0, "after_abort");
        idle_check(1, "after_abort");
    endtask

    task automatic test_random();
        logic [31:0] ra;
        logic [31:0] rb;
        int          gap;
        for (int n = 0; n < 30; n++) begin
            ra = $urandom;
            rb = $urandom;
            if (n % 5 == 0) rb = ra;
            if (n % 7 == 0) rb = ra + 32'd1;
            do_op(ra, rb, 1'($urandom_range(1)), 0, $sformatf("rand%0d", n));
            gap = $urandom_range(2);
            if (gap > 0) idle_check(gap, $sformatf("rand%0d", n));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_busy_ignore();
        test_back_to_back();
        test_reset_midrun();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
